// File: rtl/axis_audio_level_meter.sv
// Stereo peak meter on a 1-deep AXIS register slice: forwards words unmodified while
// tracking per-channel peaks with packet-counted hold/decay, a log LED bar and clip hold.
module axis_audio_level_meter #(
    parameter int DATA_WIDTH   = 24,
    parameter int LED_WIDTH    = 16,
    parameter int HOLD_PACKETS = 4800,
    parameter int DECAY_SHIFT  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic                  s_axis_last,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic                  m_axis_last,
    output logic [LED_WIDTH-1:0]  led,
    output logic                  clip,
    output logic [DATA_WIDTH-2:0] peak_l,
    output logic [DATA_WIDTH-2:0] peak_r
);

    localparam int MAG_W = DATA_WIDTH - 1;
    localparam logic [15:0] HOLD_INIT = 16'(HOLD_PACKETS);
    localparam logic [DATA_WIDTH-1:0] POS_FS = {1'b0, {MAG_W{1'b1}}};
    localparam logic [DATA_WIDTH-1:0] NEG_FS = {1'b1, {MAG_W{1'b0}}};

    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_last_q, m_last_d;

    logic [MAG_W-1:0]      peak_q [2];
    logic [MAG_W-1:0]      peak_d [2];
    logic [15:0]           hold_q [2];
    logic [15:0]           hold_d [2];
    logic [15:0]           clip_cnt_q, clip_cnt_d;
    logic                  clip_q, clip_d;
    logic [LED_WIDTH-1:0]  led_q, led_d;

    logic                  accept;
    logic                  pkt_end;
    logic                  clip_hit;
    logic [DATA_WIDTH-1:0] neg_data;
    logic [MAG_W-1:0]      mag;
    logic [MAG_W-1:0]      max_peak;

    function automatic logic [MAG_W-1:0] decayed(input logic [MAG_W-1:0] p);
        logic [MAG_W-1:0] step;
        step = p >> DECAY_SHIFT;
        if (step == '0) begin
            step = MAG_W'(1);
        end
        // step never exceeds a nonzero p, so no floor compare is needed
        return (p == '0) ? p : p - step;
    endfunction

    assign s_axis_ready = !rst && (!m_valid_q || m_axis_ready);
    assign accept       = s_axis_valid && s_axis_ready;
    assign pkt_end      = accept && s_axis_last;
    assign clip_hit     = accept && ((s_axis_data == POS_FS) || (s_axis_data == NEG_FS));

    always_comb begin
        neg_data = '0 - s_axis_data;
        mag      = s_axis_data[MAG_W-1:0];
        if (s_axis_data == NEG_FS) begin
            mag = '1;
        end else if (s_axis_data[DATA_WIDTH-1]) begin
            mag = neg_data[MAG_W-1:0];
        end
    end

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = s_axis_data;
            m_last_d  = s_axis_last;
        end else if (m_axis_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_comb begin
        for (int unsigned ch = 0; ch < 2; ch++) begin
            peak_d[ch] = peak_q[ch];
            hold_d[ch] = hold_q[ch];
            if (accept && (s_axis_last == 1'(ch)) && (mag > peak_q[ch])) begin
                peak_d[ch] = mag;
                hold_d[ch] = HOLD_INIT;
            end else if (pkt_end) begin
                if (hold_q[ch] != '0) begin
                    hold_d[ch] = hold_q[ch] - 16'd1;
                end else begin
                    peak_d[ch] = decayed(peak_q[ch]);
                end
            end
        end
    end

    always_comb begin
        clip_cnt_d = clip_cnt_q;
        if (clip_hit) begin
            clip_cnt_d = HOLD_INIT;
        end else if (pkt_end && (clip_cnt_q != '0)) begin
            clip_cnt_d = clip_cnt_q - 16'd1;
        end
        clip_d = (clip_cnt_d != '0);
    end

    always_comb begin
        max_peak = (peak_q[0] > peak_q[1]) ? peak_q[0] : peak_q[1];
        led_d    = '0;
        for (int unsigned k = 0; k < LED_WIDTH; k++) begin
            led_d[k] = ((max_peak >> (MAG_W - LED_WIDTH + int'(k))) != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_last_q   <= 1'b0;
            clip_cnt_q <= '0;
            clip_q     <= 1'b0;
            led_q      <= '0;
            for (int unsigned ch = 0; ch < 2; ch++) begin
                peak_q[ch] <= '0;
                hold_q[ch] <= '0;
            end
        end else begin
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_last_q   <= m_last_d;
            clip_cnt_q <= clip_cnt_d;
            clip_q     <= clip_d;
            led_q      <= led_d;
            for (int unsigned ch = 0; ch < 2; ch++) begin
                peak_q[ch] <= peak_d[ch];
                hold_q[ch] <= hold_d[ch];
            end
        end
    end

    assign m_axis_valid = m_valid_q;
    assign m_axis_data  = m_data_q;
    assign m_axis_last  = m_last_q;
    assign led          = led_q;
    assign clip         = clip_q;
    assign peak_l       = peak_q[0];
    assign peak_r       = peak_q[1];

endmodule

// File: tb/tb_axis_audio_level_meter.sv
// Directed plus randomized bench for axis_audio_level_meter against a queue/integer
// reference of the slice and the peak/hold/decay/clip rules.
module tb_axis_audio_level_meter;

    localparam int DW   = 24;
    localparam int LW   = 16;
    localparam int HOLD = 3;
    localparam int DS   = 1;
    localparam int MW   = DW - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] sd  = '0;
    logic          sv  = 1'b0;
    logic          sl  = 1'b0;
    logic          mr  = 1'b1;
    logic          s_axis_ready;
    logic [DW-1:0] m_axis_data;
    logic          m_axis_valid;
    logic          m_axis_last;
    logic [LW-1:0] led;
    logic          clip;
    logic [MW-1:0] peak_l;
    logic [MW-1:0] peak_r;

    axis_audio_level_meter #(
        .DATA_WIDTH  (DW),
        .LED_WIDTH   (LW),
        .HOLD_PACKETS(HOLD),
        .DECAY_SHIFT (DS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_axis_data (sd),
        .s_axis_valid(sv),
        .s_axis_ready(s_axis_ready),
        .s_axis_last (sl),
        .m_axis_data (m_axis_data),
        .m_axis_valid(m_axis_valid),
        .m_axis_ready(mr),
        .m_axis_last (m_axis_last),
        .led         (led),
        .clip        (clip),
        .peak_l      (peak_l),
        .peak_r      (peak_r)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } word_t;

    int    checks = 0;
    int    errors = 0;
    int    pk [2];
    int    hold [2];
    int    clipc;
    logic  exp_mv;
    logic  last_acc;
    word_t q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int mag_of(input logic [DW-1:0] d);
        if (d == 24'h800000) return (1 << MW) - 1;
        if (d[DW-1]) return (1 << DW) - int'(d);
        return int'(d);
    endfunction

    function automatic logic [LW-1:0] led_of(input int p);
        logic [LW-1:0] r;
        r = '0;
        for (int k = 0; k < LW; k++) r[k] = (p >= (1 << (MW - LW + k)));
        return r;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            pk[c]   = 0;
            hold[c] = 0;
        end
        clipc  = 0;
        exp_mv = 1'b0;
        q.delete();
    endtask

    task automatic model_accept(input logic [DW-1:0] d, input logic l);
        int m;
        int c;
        int step;
        bit rl [2];
        word_t w;
        m     = mag_of(d);
        c     = l ? 1 : 0;
        rl[0] = 1'b0;
        rl[1] = 1'b0;
        if (m > pk[c]) begin
            pk[c]   = m;
            hold[c] = HOLD;
            rl[c]   = 1'b1;
        end
        if (l) begin
            for (int ch = 0; ch < 2; ch++) begin
                if (!rl[ch]) begin
                    if (hold[ch] > 0) hold[ch]--;
                    else if (pk[ch] > 0) begin
                        step = pk[ch] >> DS;
                        if (step < 1) step = 1;
                        pk[ch] = (pk[ch] > step) ? pk[ch] - step : 0;
                    end
                end
            end
        end
        if (d == 24'h7FFFFF || d == 24'h800000) clipc = HOLD;
        else if (l && clipc > 0) clipc--;
        w.d = d;
        w.l = l;
        q.push_back(w);
    endtask

    task automatic tick();
        logic          exp_rdy;
        logic          acc;
        logic          xfer;
        logic [LW-1:0] led_e;
        @(negedge clk);
        exp_rdy = !rst && (!exp_mv || mr);
        chk("s_ready", 32'(s_axis_ready), 32'(exp_rdy));
        if (exp_mv && q.size() > 0) begin
            chk("m_data", 32'(m_axis_data), 32'(q[0].d));
            chk("m_last", 32'(m_axis_last), 32'(q[0].l));
        end
        acc   = sv && exp_rdy;
        xfer  = exp_mv && mr && !rst;
        led_e = rst ? '0 : led_of((pk[0] > pk[1]) ? pk[0] : pk[1]);
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            if (xfer) void'(q.pop_front());
            if (acc) model_accept(sd, sl);
            exp_mv = acc || (exp_mv && !mr);
        end
        last_acc = acc;
        chk("m_valid", 32'(m_axis_valid), 32'(exp_mv));
        chk("peak_l", 32'(peak_l), 32'(pk[0]));
        chk("peak_r", 32'(peak_r), 32'(pk[1]));
        chk("led", 32'(led), 32'(led_e));
        chk("clip", 32'(clip), 32'(clipc != 0));
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        sd = d;
        sl = l;
        sv = 1'b1;
        last_acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_acc) break;
        end
        chk("send_accepted", 32'(last_acc), 32'(1));
    endtask

    task automatic idle(input int n);
        sv = 1'b0;
        repeat (n) tick();
    endtask

    task automatic packet(input logic [DW-1:0] dl, input logic [DW-1:0] dr);
        send(dl, 1'b0);
        send(dr, 1'b1);
        idle(1);
    endtask

    task automatic rst_now();
        rst = 1'b1;
        #1;
        chk("rst_m_valid", 32'(m_axis_valid), 32'(0));
        chk("rst_m_data", 32'(m_axis_data), 32'(0));
        chk("rst_m_last", 32'(m_axis_last), 32'(0));
        chk("rst_s_ready", 32'(s_axis_ready), 32'(0));
        chk("rst_peak_l", 32'(peak_l), 32'(0));
        chk("rst_peak_r", 32'(peak_r), 32'(0));
        chk("rst_led", 32'(led), 32'(0));
        chk("rst_clip", 32'(clip), 32'(0));
        model_reset();
    endtask

    task automatic do_reset();
        sv = 1'b0;
        rst_now();
        tick();
        rst = 1'b0;
        tick();
    endtask

    function automatic logic [DW-1:0] rand_sample();
        logic [DW-1:0] x;
        case ($urandom_range(0, 6))
            0: x = 24'h7FFFFF;
            1: x = 24'h800000;
            2: x = '0;
            3: x = DW'($urandom());
            default: begin
                x = DW'($urandom_range(0, (1 << $urandom_range(0, 22)) - 1));
                if ($urandom_range(0, 1) == 1) x = '0 - x;
            end
        endcase
        return x;
    endfunction

    initial begin
        model_reset();
        last_acc = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // T1 pass-through
        mr = 1'b1;
        send(24'h123456, 1'b0);
        chk("t1_data0", 32'(m_axis_data), 32'h123456);
        chk("t1_last0", 32'(m_axis_last), 32'(0));
        send(24'hFEDCBA, 1'b1);
        chk("t1_data1", 32'(m_axis_data), 32'hFEDCBA);
        chk("t1_last1", 32'(m_axis_last), 32'(1));
        idle(2);

        // T2 backpressure
        mr = 1'b0;
        send(24'h0A0B0C, 1'b0);
        sd = 24'h0D0E0F;
        sl = 1'b1;
        sv = 1'b1;
        repeat (3) begin
            tick();
            chk("t2_held", 32'(m_axis_data), 32'h0A0B0C);
        end
        mr = 1'b1;
        tick();
        chk("t2_next", 32'(m_axis_data), 32'h0D0E0F);
        idle(3);

        // T3 LED scale
        do_reset();
        send(24'h000100, 1'b0);
        idle(2);
        chk("t3_led_small", 32'(led), 32'h0003);
        send(24'h400000, 1'b0);
        idle(2);
        chk("t3_led_full", 32'(led), 32'hFFFF);
        chk("t3_peak_l", 32'(peak_l), 32'h400000);

        // T4 clip / saturation
        do_reset();
        send(24'h800000, 1'b0);
        idle(2);
        chk("t4_peak_l", 32'(peak_l), 32'h7FFFFF);
        chk("t4_clip", 32'(clip), 32'(1));
        packet('0, '0);
        chk("t4_clip_p1", 32'(clip), 32'(1));
        packet('0, '0);
        chk("t4_clip_p2", 32'(clip), 32'(1));
        packet('0, '0);
        chk("t4_clip_p3", 32'(clip), 32'(0));

        // T5 hold / decay
        do_reset();
        send(24'h400000, 1'b1);
        idle(1);
        for (int i = 0; i < HOLD; i++) begin
            packet('0, '0);
            chk("t5_hold", 32'(peak_r), 32'h400000);
        end
        packet('0, '0);
        chk("t5_decay1", 32'(peak_r), 32'h200000);
        packet('0, '0);
        chk("t5_decay2", 32'(peak_r), 32'h100000);
        do_reset();
        send(24'h000001, 1'b1);
        idle(1);
        for (int i = 0; i < HOLD; i++) packet('0, '0);
        chk("t5_one_held", 32'(peak_r), 32'(1));
        packet('0, '0);
        chk("t5_one_zero", 32'(peak_r), 32'(0));

        // T6 reset with a word stalled on the output
        do_reset();
        mr = 1'b0;
        send(24'hABCDEF, 1'b0);
        idle(1);
        chk("t6_stalled", 32'(m_axis_valid), 32'(1));
        rst_now();
        tick();
        rst = 1'b0;
        mr  = 1'b1;
        tick();
        packet(24'h000200, 24'h000080);
        chk("t6_peak_l", 32'(peak_l), 32'h000200);
        chk("t6_peak_r", 32'(peak_r), 32'h000080);

        // randomized traffic with random backpressure
        for (int i = 0; i < 600; i++) begin
            sv = ($urandom_range(0, 3) != 0);
            mr = ($urandom_range(0, 3) != 0);
            sd = rand_sample();
            sl = 1'($urandom_range(0, 1));
            tick();
        end
        mr = 1'b1;
        idle(3);
        chk("queue_drained", 32'(q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
